// File: rtl/galois_pkg.sv
// -----------------------------------------------------------------------------
// galois_pkg
// Shared constants and types for the streaming Barrett GF(p) multiplier.
//   - BN254 scalar-field prime and its Barrett constant floor(4^254 / p)
//   - pipeline depth
//   - default per-stage sideband record {tag, err}
// No ports (package).
// -----------------------------------------------------------------------------
package galois_pkg;

   localparam int PIPE_STAGES      = 4;
   localparam int BN254_BITS       = 254;
   localparam int TAG_BITS_DEFAULT = 8;

   localparam logic [253:0] BN254_P =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   // Barrett constant folded at elaboration time: floor(2^508 / p), 255 bits.
   localparam logic [508:0] BN254_FOUR_POW = {1'b1, 508'd0};
   localparam logic [508:0] BN254_R_FULL   = BN254_FOUR_POW / {255'd0, BN254_P};
   localparam logic [254:0] BN254_R        = BN254_R_FULL[254:0];

   // Sideband that travels with every operation (default tag width).
   typedef struct packed {
      logic [TAG_BITS_DEFAULT-1:0] tag;
      logic                        err;
   } galois_side_t;

endpackage

// File: rtl/galois_pipe_slice.sv
// -----------------------------------------------------------------------------
// galois_pipe_slice
// Generic elastic stage register: a payload of WIDTH bits plus a valid bit.
// The stage loads when en is high; payload only updates when a valid item
// arrives, so a drained or stalled stage keeps its last data stable.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (clears valid and payload)
//   en        in   stage may load this cycle
//   in_valid  in   upstream item present
//   in_data   in   upstream payload
//   out_valid out  stage occupied
//   out_data  out  stage payload
// -----------------------------------------------------------------------------
module galois_pipe_slice
   import galois_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   // Stage register: capture the upstream item whenever the stage is enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= {WIDTH{1'b0}};
      end else if (en) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/galois_mult_barrett_stream.sv
// -----------------------------------------------------------------------------
// galois_mult_barrett_stream
// Streaming four-stage Barrett modular multiplier: product = (num1*num2) mod p,
// one result per cycle, valid/ready on both sides, bubble-collapsing stages.
//   S1: x = num1*num2
//   S2: q = ((x >> (N-1)) * R) >> (N+1)
//   S3: r = (x - q*p) mod 2^(N+2)
//   S4: up to two conditional subtractions of p
// Optional feature macro: GALOIS_MULT_OPERAND_CHECK_EN -- registers an
// operand-range flag (num1 >= p or num2 >= p) that travels to out_err.
// Without it out_err is tied low and no comparators are built.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready combinational from
//                         out_ready and stage occupancy only)
//   num1, num2, in_tag    operands (< p) and opaque sideband
//   out_valid/out_ready   output handshake
//   product, out_tag      result and its tag
//   out_err               operand-range flag
// -----------------------------------------------------------------------------
module galois_mult_barrett_stream
   import galois_pkg::*;
#(
   parameter int                N_BITS        = BN254_BITS,
   parameter logic [N_BITS-1:0] PRIME_MODULUS = BN254_P,
   parameter logic [N_BITS:0]   BARRETT_R     = BN254_R,
   parameter int                TAG_BITS      = TAG_BITS_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N_BITS-1:0]   num1,
   input  logic [N_BITS-1:0]   num2,
   input  logic [TAG_BITS-1:0] in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N_BITS-1:0]   product,
   output logic [TAG_BITS-1:0] out_tag,
   output logic                out_err
);

   localparam int XW = 2 * N_BITS;   // full product width
   localparam int QW = N_BITS + 1;   // quotient estimate width
   localparam int RW = N_BITS + 2;   // remainder width, holds values < 3p

   typedef struct packed {
      logic [TAG_BITS-1:0] tag;
      logic                err;
   } stage_side_t;

   localparam int SW = $bits(stage_side_t);

   logic en1_s, en2_s, en3_s, en4_s;
   logic v1_r, v2_r, v3_r, v4_r;

   stage_side_t side0_s, side1_r, side2_r, side3_r, side4_r;
   logic [XW-1:0]     x0_s, x1_r, x2_r;
   logic [2*QW-1:0]   qr_s;
   logic [QW-1:0]     q1_s, q2_r;
   logic [RW-1:0]     qp_s, r2_s, r3_r, red_a_s, red_b_s;
   logic [N_BITS-1:0] prod4_r;

   logic [XW+SW-1:0]    s1_d_r;
   logic [XW+QW+SW-1:0] s2_d_r;
   logic [RW+SW-1:0]    s3_d_r;
   logic [N_BITS+SW-1:0] s4_d_r;

   // Bubble-collapsing enables: a stage advances if empty or its successor advances.
   always_comb begin
      en4_s = !v4_r | out_ready;
      en3_s = !v3_r | en4_s;
      en2_s = !v2_r | en3_s;
      en1_s = !v1_r | en2_s;
   end

   assign in_ready = en1_s;

   // S1 input: full-width product and sideband (optional range flag).
   always_comb begin
      x0_s        = {{N_BITS{1'b0}}, num1} * {{N_BITS{1'b0}}, num2};
      side0_s.tag = in_tag;
`ifdef GALOIS_MULT_OPERAND_CHECK_EN
      side0_s.err = (num1 >= PRIME_MODULUS) | (num2 >= PRIME_MODULUS);
`else
      side0_s.err = 1'b0;
`endif
   end

   galois_pipe_slice #(.WIDTH(XW + SW)) u_s1 (
      .clk(clk), .rst_n(rst_n), .en(en1_s), .in_valid(in_valid),
      .in_data({x0_s, side0_s}), .out_valid(v1_r), .out_data(s1_d_r)
   );
   assign x1_r    = s1_d_r[XW+SW-1:SW];
   assign side1_r = s1_d_r[SW-1:0];

   // S2 input: Barrett quotient estimate; the discarded low bits are never needed.
   always_comb begin
      qr_s = {{QW{1'b0}}, x1_r[XW-1:N_BITS-1]} * {{QW{1'b0}}, BARRETT_R};
      q1_s = qr_s[2*QW-1:QW];
   end

   galois_pipe_slice #(.WIDTH(XW + QW + SW)) u_s2 (
      .clk(clk), .rst_n(rst_n), .en(en2_s), .in_valid(v1_r),
      .in_data({x1_r, q1_s, side1_r}), .out_valid(v2_r), .out_data(s2_d_r)
   );
   assign x2_r    = s2_d_r[XW+QW+SW-1:QW+SW];
   assign q2_r    = s2_d_r[QW+SW-1:SW];
   assign side2_r = s2_d_r[SW-1:0];

   // S3 input: remainder modulo 2^(N+2); true value is < 3p so the wrap is harmless.
   always_comb begin
      qp_s = {1'b0, q2_r} * {2'b00, PRIME_MODULUS};
      r2_s = x2_r[RW-1:0] - qp_s;
   end

   galois_pipe_slice #(.WIDTH(RW + SW)) u_s3 (
      .clk(clk), .rst_n(rst_n), .en(en3_s), .in_valid(v2_r),
      .in_data({r2_s, side2_r}), .out_valid(v3_r), .out_data(s3_d_r)
   );
   assign r3_r    = s3_d_r[RW+SW-1:SW];
   assign side3_r = s3_d_r[SW-1:0];

   // S4 input: two conditional subtractions bring r from [0, 3p) into [0, p).
   always_comb begin
      red_a_s = r3_r;
      red_b_s = r3_r;
      if (r3_r >= {2'b00, PRIME_MODULUS}) begin
         red_a_s = r3_r - {2'b00, PRIME_MODULUS};
      end else begin
         red_a_s = r3_r;
      end
      if (red_a_s >= {2'b00, PRIME_MODULUS}) begin
         red_b_s = red_a_s - {2'b00, PRIME_MODULUS};
      end else begin
         red_b_s = red_a_s;
      end
   end

   galois_pipe_slice #(.WIDTH(N_BITS + SW)) u_s4 (
      .clk(clk), .rst_n(rst_n), .en(en4_s), .in_valid(v3_r),
      .in_data({red_b_s[N_BITS-1:0], side3_r}), .out_valid(v4_r), .out_data(s4_d_r)
   );
   assign prod4_r = s4_d_r[N_BITS+SW-1:SW];
   assign side4_r = s4_d_r[SW-1:0];

   assign out_valid = v4_r;
   assign product   = prod4_r;
   assign out_tag   = side4_r.tag;
`ifdef GALOIS_MULT_OPERAND_CHECK_EN
   assign out_err   = side4_r.err;
`else
   assign out_err   = 1'b0;
`endif

   // Bits that are architecturally dropped by the Barrett arithmetic.
   logic unused_bits_s;
   assign unused_bits_s = ^{qr_s[QW-1:0], x2_r[XW-1:RW], red_b_s[RW-1:N_BITS], side4_r.err};

endmodule

// File: doc/galois_mult_barrett_stream.md
# galois_mult_barrett_stream

Streaming, fully pipelined Barrett modular multiplier over GF(p). It computes (num1·num2) mod PRIME_MODULUS at one result per cycle, with valid/ready flow control, bubble-collapsing stages and a tag sideband carried alongside each operation. It is the elastic successor to the free-running synchronous multiplier and sits between the Griffin round scheduler and the S-box/linear-layer datapath. Those consumers can stall, so the block must hold data under backpressure without losing or reordering it.

## Interface
- N_BITS, 254: operand/result width; must be ≥ 8.
- PRIME_MODULUS, BN254 scalar prime 0x30644e72…f0000001: modulus p; N_BITS bits, MSB set.
- BARRETT_R, 0x54a47462…be1de925: floor(4^N_BITS / p); N_BITS+1 bits.
- TAG_BITS, 8: sideband width; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept this cycle.
- num1, num2  in  N_BITS each  operands; must be < p.
- in_tag  in  TAG_BITS  opaque sideband.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts.
- product  out  N_BITS  (num1·num2) mod p.
- out_tag  out  TAG_BITS  tag of that operation.
- out_err  out  1  operand-range flag (see Configuration).

## Operation
- Four register stages, each with a valid bit v1..v4. Every stage register and valid bit is cleared by rst_n.
- S1: x = num1·num2, 2·N_BITS bits.
- S2: q = ((x >> (N_BITS−1)) · BARRETT_R) >> (N_BITS+1). x is carried forward.
- S3: r = (x − q·p) mod 2^(N_BITS+2). Only the low N_BITS+2 bits are computed, so wrap-around is intended.
- S4: r is reduced to [0, p) using at most two conditional subtractions of p. The result is guaranteed < p for all operands < p.
- Stage enables (bubble-collapse):
  - en4 = !v4 | out_ready.
  - en_i = !v_i | en_(i+1).
  - in_ready = en1.
- Accept on in_valid & in_ready; output transfer on out_valid & out_ready.
- An empty stage is always filled, even while downstream is stalled.
- Order is strictly preserved. The tag travels with its data unchanged.
- Data in a stalled stage holds stable. product, out_tag and out_err must not change while out_valid & !out_ready.
- Simultaneous accept and output on the same edge is supported at full throughput.
- When no stage is occupied, in_ready = 1.
- When all four stages are full and out_ready = 0, in_ready = 0.
- Reset mid-stream discards all in-flight operations; no partial output is produced.
- Behaviour with operands ≥ p is undefined except as given under Configuration.

## Timing
- Reset values: out_valid = 0, product = 0, out_tag = 0, out_err = 0. in_ready = 1 once rst_n deasserts.
- Latency: accepted on edge E → out_valid = 1 with the result immediately after edge E+3, provided no stall. The consumer takes it on edge E+4 if out_ready.
- Throughput: one operation per cycle with out_ready held high.
- in_ready is combinational from out_ready and v1..v4. No combinational path from in_valid to in_ready or to out_valid.
- Capacity: 4 operations in flight.

## Configuration
- GALOIS_MULT_OPERAND_CHECK_EN defined: S1 additionally registers err = (num1 ≥ p) | (num2 ≥ p). err travels with the operation to out_err. product is still computed but is not guaranteed reduced when err = 1.
- Not defined: no comparators are built and out_err is tied to 0.

## Structure
- Package galois_pkg holds:
  - BN254 PRIME_MODULUS and BARRETT_R constants;
  - localparam PIPE_STAGES = 4;
  - a packed struct typedef for the per-stage sideband {tag, err}.
- Sub-module galois_pipe_slice: a generic stage register with valid bit, enable input and async-low reset, parametrised by payload width. It is instantiated four times. The arithmetic lives in the top module between the slices.

## Test plan
- Reset, then pairs (1,13), (2,14), …, (12,24) on consecutive cycles with out_ready = 1 → products 13, 28, …, 288; first result after edge E+3, then one per cycle; tags 0..11 in order.
- (p−1, p−1) → 1. (p−1, 2) → p−2. (0, p−1) → 0. A random sweep of 10k operand pairs checked against a reference model using % p.
- out_ready = 0 for 8 cycles while in_valid = 1 continuously → exactly 4 accepted, in_ready = 0 thereafter, outputs held stable. Then out_ready = 1 → the 4 results are delivered in order with no gaps, and in_ready returns the same cycle.
- Random in_valid/out_ready toggling at 50% each for 5k cycles → no loss, no duplication, no reordering. The output is stable whenever out_valid & !out_ready.
- rst_n pulsed low asynchronously (mid-clock) with 3 operations in flight → out_valid = 0 immediately. After release, the next accepted (3,5) yields 15 with no stale output.
- With GALOIS_MULT_OPERAND_CHECK_EN: num1 = p, num2 = 1 → out_err = 1. num1 = p−1 → out_err = 0. Without the macro, out_err stays 0 throughout.
